// File: rtl/bounded_response_checker.sv
// Multi-channel checker for "trig |-> ##[MIN_DLY:MAX_DLY] resp" with overlapping attempts.
// Optional first-fail log (channel + cycle stamp) enabled by defining BRC_FIRST_FAIL_LOG_EN.
module bounded_response_checker #(
  parameter int N_CH    = 1,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 5,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   trig,
  input  logic [N_CH-1:0]   resp,
  output logic [N_CH-1:0]   pass,
  output logic [N_CH-1:0]   fail,
  output logic [N_CH-1:0]   busy,
  output logic [CNT_W-1:0]  attempt_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
`ifdef BRC_FIRST_FAIL_LOG_EN
  ,
  output logic              first_fail_vld,
  output logic [$clog2((N_CH > 1) ? N_CH : 2)-1:0] first_fail_ch,
  output logic [CNT_W-1:0]  first_fail_time
`endif
);

  localparam int INC_W = 10;

  if (N_CH < 1 || N_CH > 16 || MIN_DLY < 1 || MIN_DLY > MAX_DLY || MAX_DLY > 32) begin : g_param_err
    $error("bounded_response_checker: illegal N_CH/MIN_DLY/MAX_DLY combination");
  end

  // Bit j of an age vector holds an attempt whose age at the current edge is j+1.
  localparam logic [MAX_DLY-1:0] WIN_MASK = {MAX_DLY{1'b1}} << (MIN_DLY - 1);

  logic [MAX_DLY-1:0] age_q [N_CH];
  logic [MAX_DLY-1:0] age_d [N_CH];
  logic [MAX_DLY-1:0] hit_v [N_CH];
  logic [N_CH-1:0]    hit_any;
  logic [N_CH-1:0]    expire;
  logic [INC_W-1:0]   att_inc;
  logic [INC_W-1:0]   pass_inc;
  logic [INC_W-1:0]   fail_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [INC_W-1:0] b);
    logic [CNT_W+INC_W:0] s;
    s = {{(INC_W+1){1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
    if (s > {{(INC_W+1){1'b0}}, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    att_inc  = '0;
    pass_inc = '0;
    fail_inc = '0;
    hit_any  = '0;
    expire   = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit_v[c]   = resp[c] ? (age_q[c] & WIN_MASK) : '0;
      hit_any[c] = |hit_v[c];
      // A satisfied oldest attempt is a pass, so expiry needs resp low.
      expire[c]  = ~resp[c] & age_q[c][MAX_DLY-1];
      age_d[c]    = (age_q[c] & ~hit_v[c]) << 1;
      age_d[c][0] = trig[c] & en;
      att_inc  = att_inc + INC_W'(trig[c] & en);
      fail_inc = fail_inc + INC_W'(expire[c]);
      for (int j = 0; j < MAX_DLY; j++) begin
        pass_inc = pass_inc + INC_W'(hit_v[c][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) age_q[c] <= '0;
      pass        <= '0;
      fail        <= '0;
      busy        <= '0;
      attempt_cnt <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        age_q[c] <= age_d[c];
        busy[c]  <= |age_d[c];
      end
      pass        <= hit_any;
      fail        <= expire;
      attempt_cnt <= sat_add(attempt_cnt, att_inc);
      pass_cnt    <= sat_add(pass_cnt, pass_inc);
      fail_cnt    <= sat_add(fail_cnt, fail_inc);
    end
  end

`ifdef BRC_FIRST_FAIL_LOG_EN
  localparam int FCH_W = $clog2((N_CH > 1) ? N_CH : 2);

  logic [CNT_W-1:0] cyc_q;
  logic [FCH_W-1:0] low_ch;

  always_comb begin
    low_ch = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (expire[c]) low_ch = FCH_W'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q           <= '0;
      first_fail_vld  <= 1'b0;
      first_fail_ch   <= '0;
      first_fail_time <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (!first_fail_vld && (|expire)) begin
        first_fail_vld  <= 1'b1;
        first_fail_ch   <= low_ch;
        first_fail_time <= cyc_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bounded_response_checker.sv
// Directed scoreboard bench: N_CH=2, MIN_DLY=2, MAX_DLY=4, CNT_W=3 (small counters to reach saturation).
module tb_bounded_response_checker;

  localparam int N  = 2;
  localparam int CW = 3;
  localparam int W  = 3 * N + 3 * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  trig;
  logic [N-1:0]  resp;
  logic [N-1:0]  pass;
  logic [N-1:0]  fail;
  logic [N-1:0]  busy;
  logic [CW-1:0] attempt_cnt;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
`ifdef BRC_FIRST_FAIL_LOG_EN
  logic          first_fail_vld;
  logic [0:0]    first_fail_ch;
  logic [CW-1:0] first_fail_time;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int row    = 0;

  bounded_response_checker #(
    .N_CH(N), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .resp(resp),
    .pass(pass), .fail(fail), .busy(busy),
    .attempt_cnt(attempt_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef BRC_FIRST_FAIL_LOG_EN
    , .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
    .first_fail_time(first_fail_time)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: inputs change on negedge; the expected post-edge outputs are queued.
  task automatic step(input logic r, input logic e, input logic [N-1:0] t, input logic [N-1:0] rs,
                      input logic [N-1:0] p, input logic [N-1:0] f, input logic [N-1:0] b,
                      input logic [CW-1:0] a, input logic [CW-1:0] pc, input logic [CW-1:0] fc);
    @(negedge clk);
    rst  = r;
    en   = e;
    trig = t;
    resp = rs;
    exp_q.push_back({p, f, b, a, pc, fc});
  endtask

  task automatic check(input string name, input int r, input logic [W-1:0] act,
                       input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, r, act, exp_v);
    end
  endtask

  // Monitor / scoreboard: samples 2 time units after each posedge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulses",   row, W'({pass, fail}), W'(e[W-1 -: 2*N]));
        check("busy",     row, W'(busy), W'(e[3*CW +: N]));
        check("counters", row, W'({attempt_cnt, pass_cnt, fail_cnt}), W'(e[3*CW-1:0]));
        row++;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; trig = '0; resp = '0;
    //    rst en  trig   resp   pass   fail   busy   att pcnt fcnt
    step(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0); // reset state
    // ch0: resp at age 1 ignored, pass at age 2
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0);
    step(0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 0);
    step(0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 0);
    // ch1: resp at k=0 and k=1 do not satisfy, expires at k=4
    step(0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2, 1, 0);
    step(0, 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2, 1, 0);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2, 1, 0);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2, 1, 0);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2, 1, 1);
    // ch0: resp exactly at k=MAX passes; new attempt on that edge survives it
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 3, 1, 1);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3, 1, 1);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3, 1, 1);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3, 1, 1);
    step(0, 1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 4, 2, 1);
    step(0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 4, 2, 1);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4, 2, 1);
    step(0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 4, 3, 1);
    // en=0 blocks starts; one resp clears two attempts; counters saturate at 7
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 5, 3, 1);
    step(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 5, 3, 1);
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 6, 3, 1);
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 7, 3, 1);
    step(0, 1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 7, 5, 1);
    step(0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 7, 6, 1);
    step(0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 7, 7, 1);
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 7, 7, 1);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 7, 7, 1);
    step(0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 7, 7, 1);
    // reset with attempts pending: discarded, no later fail
    step(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 7, 7, 1);
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 7, 7, 1);
    step(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    end
    // both channels fail on one edge, then ch0 fails again next edge
    step(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2, 0, 0);
    step(0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 3, 0, 0);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 3, 0, 0);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 3, 0, 0);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 3, 0, 2);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3, 0, 3);
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3, 0, 3);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
